// File: rtl/axis_stage_pkg.sv
// Shared helpers for decimating AXI-stream stages.
//   acc_width(data_w, dec) : accumulator width that cannot overflow summing dec samples
//   is_pow2(n)             : true when n is a non-zero power of two
package axis_stage_pkg;

  // Summing dec samples of data_w bits grows the magnitude by at most log2(dec) bits.
  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned dec);
    return data_w + $clog2(dec);
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/axis_decimating_accumulator.sv
// Sums every DECIMATION accepted signed samples into one output sample,
// optionally scaled down to the average (arithmetic shift, floor toward -inf).
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   clear               drop the partial window; a sample accepted in the same
//                       cycle becomes the first sample of the new window
//   in_valid/in_ready   input handshake, in_ready = !out_valid || out_ready
//   in_data             signed input sample
//   out_valid/out_ready single-entry output register handshake
//   out_data            signed sum (AVERAGE=0) or average (AVERAGE=1)
//   window_count        samples accumulated in the current window
module axis_decimating_accumulator
  import axis_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DECIMATION = 8,
  parameter int unsigned AVERAGE    = 1,
  localparam int unsigned OUT_WIDTH = (AVERAGE != 0) ? DATA_WIDTH
                                                     : acc_width(DATA_WIDTH, DECIMATION),
  localparam int unsigned CNT_WIDTH = (DECIMATION > 1) ? $clog2(DECIMATION) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [CNT_WIDTH-1:0]  window_count
);

  localparam int unsigned ACC_W = acc_width(DATA_WIDTH, DECIMATION);
  localparam int unsigned SHIFT = $clog2(DECIMATION);

  // Averaging is a plain shift, so it is only defined for power-of-two windows.
  if (DECIMATION == 0 || (AVERAGE != 0 && !is_pow2(DECIMATION))) begin : g_bad_cfg
    $error("axis_decimating_accumulator: invalid DECIMATION/AVERAGE combination");
  end

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;

  logic                    accept;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] base_acc;
  logic [CNT_WIDTH-1:0]    base_cnt;
  logic signed [ACC_W-1:0] sum;
  logic                    last;

  assign in_ready     = !out_valid_q || out_ready;
  assign accept       = in_valid && in_ready;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign window_count = cnt_q;

  // Window update; clear wipes the partial window before the current sample is added.
  always_comb begin
    in_ext      = ACC_W'($signed(in_data));
    base_acc    = clear ? '0 : acc_q;
    base_cnt    = clear ? '0 : cnt_q;
    sum         = base_acc + in_ext;
    last        = (base_cnt == CNT_WIDTH'(DECIMATION - 1));
    acc_d       = base_acc;
    cnt_d       = base_cnt;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;

    if (accept) begin
      if (last) begin
        // A completion reloads the output register even if the old entry is consumed this cycle.
        out_valid_d = 1'b1;
        if (AVERAGE != 0) out_data_d = OUT_WIDTH'(sum >>> SHIFT);
        else              out_data_d = OUT_WIDTH'(sum);
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = base_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_axis_decimating_accumulator.sv
// Directed bench: four configurations of axis_decimating_accumulator.
//   A: DATA_WIDTH=32 DECIMATION=8 AVERAGE=0  (table + backpressure + mid-window reset)
//   B: DATA_WIDTH=16 DECIMATION=4 AVERAGE=1  (floor averaging of negatives)
//   C: DATA_WIDTH=16 DECIMATION=8 AVERAGE=0  (extreme values, no wrap)
//   D: DATA_WIDTH=8  DECIMATION=1 AVERAGE=1  (passthrough, consume+load same edge)
module tb_axis_decimating_accumulator;

  logic clk;
  logic rst;
  logic a_rst;

  logic        a_clear, a_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_data;
  logic [34:0] a_out_data;
  logic [2:0]  a_cnt;

  logic        b_clear, b_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_data;
  logic [15:0] b_out_data;
  logic [1:0]  b_cnt;

  logic        c_clear, c_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [15:0] c_data;
  logic [18:0] c_out_data;
  logic [2:0]  c_cnt;

  logic        d_clear, d_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [7:0]  d_data;
  logic [7:0]  d_out_data;
  logic [0:0]  d_cnt;

  int checks = 0;
  int errors = 0;

  axis_decimating_accumulator #(.DATA_WIDTH(32), .DECIMATION(8), .AVERAGE(0)) u_a (
    .clock(clk), .reset(a_rst), .clear(a_clear), .in_valid(a_valid), .in_ready(a_in_ready),
    .in_data(a_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .window_count(a_cnt));

  axis_decimating_accumulator #(.DATA_WIDTH(16), .DECIMATION(4), .AVERAGE(1)) u_b (
    .clock(clk), .reset(rst), .clear(b_clear), .in_valid(b_valid), .in_ready(b_in_ready),
    .in_data(b_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .window_count(b_cnt));

  axis_decimating_accumulator #(.DATA_WIDTH(16), .DECIMATION(8), .AVERAGE(0)) u_c (
    .clock(clk), .reset(rst), .clear(c_clear), .in_valid(c_valid), .in_ready(c_in_ready),
    .in_data(c_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .window_count(c_cnt));

  axis_decimating_accumulator #(.DATA_WIDTH(8), .DECIMATION(1), .AVERAGE(1)) u_d (
    .clock(clk), .reset(rst), .clear(d_clear), .in_valid(d_valid), .in_ready(d_in_ready),
    .in_data(d_data), .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
    .window_count(d_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        clr;
    logic        vld;
    logic [31:0] din;
    logic        rdy;
    logic        e_ir;
    logic        e_ov;
    logic [34:0] e_od;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic clr, input logic vld, input int din, input logic rdy,
                             input logic e_ir, input logic e_ov, input int e_od, input int e_cnt);
    vec_t r;
    r.clr = clr; r.vld = vld; r.din = 32'(din); r.rdy = rdy;
    r.e_ir = e_ir; r.e_ov = e_ov; r.e_od = 35'(e_od); r.e_cnt = 3'(e_cnt);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle on A; in_ready checked before the edge, registered outputs after it.
  // out_data is only required when out_valid is expected.
  task automatic step_a(input string tag, input logic clr, input logic vld, input logic [31:0] din,
                        input logic rdy, input logic e_ir, input logic e_ov,
                        input logic [34:0] e_od, input logic [2:0] e_cnt);
    a_clear = clr; a_valid = vld; a_data = din; a_out_ready = rdy;
    #1;
    chk({tag, "_in_ready"}, 64'(a_in_ready), 64'(e_ir));
    @(posedge clk); #1;
    a_clear = 1'b0; a_valid = 1'b0;
    chk({tag, "_out_valid"}, 64'(a_out_valid), 64'(e_ov));
    chk({tag, "_count"}, 64'(a_cnt), 64'(e_cnt));
    if (e_ov) chk({tag, "_out_data"}, 64'(a_out_data), 64'(e_od));
  endtask

  task automatic step_b(input string tag, input logic [15:0] din, input logic e_ov,
                        input logic [15:0] e_od, input logic [1:0] e_cnt);
    b_valid = 1'b1; b_data = din; b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    chk({tag, "_out_valid"}, 64'(b_out_valid), 64'(e_ov));
    chk({tag, "_count"}, 64'(b_cnt), 64'(e_cnt));
    if (e_ov) chk({tag, "_out_data"}, 64'(b_out_data), 64'(e_od));
  endtask

  task automatic step_c(input string tag, input logic [15:0] din, input logic e_ov,
                        input logic [18:0] e_od, input logic [2:0] e_cnt);
    c_valid = 1'b1; c_data = din; c_out_ready = 1'b1;
    @(posedge clk); #1;
    c_valid = 1'b0;
    chk({tag, "_out_valid"}, 64'(c_out_valid), 64'(e_ov));
    chk({tag, "_count"}, 64'(c_cnt), 64'(e_cnt));
    if (e_ov) chk({tag, "_out_data"}, 64'(c_out_data), 64'(e_od));
  endtask

  task automatic step_d(input string tag, input logic clr, input logic vld, input logic [7:0] din,
                        input logic rdy, input logic e_ir, input logic e_ov, input logic [7:0] e_od);
    d_clear = clr; d_valid = vld; d_data = din; d_out_ready = rdy;
    #1;
    chk({tag, "_in_ready"}, 64'(d_in_ready), 64'(e_ir));
    @(posedge clk); #1;
    d_clear = 1'b0; d_valid = 1'b0;
    chk({tag, "_out_valid"}, 64'(d_out_valid), 64'(e_ov));
    chk({tag, "_count"}, 64'(d_cnt), 64'(0));
    if (e_ov) chk({tag, "_out_data"}, 64'(d_out_data), 64'(e_od));
  endtask

  initial begin
    rst = 1'b1; a_rst = 1'b1;
    a_clear = 0; a_valid = 0; a_data = '0; a_out_ready = 0;
    b_clear = 0; b_valid = 0; b_data = '0; b_out_ready = 0;
    c_clear = 0; c_valid = 0; c_data = '0; c_out_ready = 0;
    d_clear = 0; d_valid = 0; d_data = '0; d_out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; a_rst = 1'b0;

    // Reset state of every configuration.
    chk("rst_a_in_ready", 64'(a_in_ready), 64'(1));
    chk("rst_a_out_valid", 64'(a_out_valid), 64'(0));
    chk("rst_a_out_data", 64'(a_out_data), 64'(0));
    chk("rst_a_count", 64'(a_cnt), 64'(0));
    chk("rst_b_out_valid", 64'(b_out_valid), 64'(0));
    chk("rst_b_out_data", 64'(b_out_data), 64'(0));
    chk("rst_c_count", 64'(c_cnt), 64'(0));
    chk("rst_d_in_ready", 64'(d_in_ready), 64'(1));

    // Table for A: 1..8 -> 36; clear on 3rd sample then 2s -> 16; lone clear; mixed-sign window -> 72.
    for (int i = 1; i <= 7; i++) tbl.push_back(v(0, 1, i, 1, 1, 0, 0, i));
    tbl.push_back(v(0, 1, 8, 1, 1, 1, 36, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(0, 1, 5, 1, 1, 0, 0, 1));
    tbl.push_back(v(0, 1, 6, 1, 1, 0, 0, 2));
    tbl.push_back(v(1, 1, 2, 1, 1, 0, 0, 1));
    for (int i = 2; i <= 7; i++) tbl.push_back(v(0, 1, 2, 1, 1, 0, 0, i));
    tbl.push_back(v(0, 1, 2, 1, 1, 1, 16, 0));
    tbl.push_back(v(0, 1, 9, 1, 1, 0, 0, 1));
    tbl.push_back(v(1, 0, 0, 1, 1, 0, 0, 0));
    for (int i = 1; i <= 7; i++) tbl.push_back(v(0, 1, -i, 1, 1, 0, 0, i));
    tbl.push_back(v(0, 1, 100, 1, 1, 1, 72, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++)
      step_a($sformatf("tbl%0d", i), tbl[i].clr, tbl[i].vld, tbl[i].din, tbl[i].rdy,
             tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_od, tbl[i].e_cnt);

    // Backpressure: complete 10..80 with out_ready low, stall, then release and send 1..8.
    for (int i = 1; i <= 8; i++)
      step_a($sformatf("bp_fill%0d", i), 0, 1, 32'(10 * i), 0, 1, (i == 8), 35'(360), 3'(i % 8));
    for (int i = 0; i < 3; i++)
      step_a($sformatf("bp_stall%0d", i), 0, 1, 32'(1), 0, 0, 1, 35'(360), 3'(0));
    for (int i = 1; i <= 8; i++)
      step_a($sformatf("bp_drain%0d", i), 0, 1, 32'(i), 1, 1, (i == 8), 35'(36), 3'(i % 8));

    // Reset at count 5 drops the partial window and the pending output.
    for (int i = 1; i <= 5; i++)
      step_a($sformatf("rw_pre%0d", i), 0, 1, 32'(3), 1, 1, 0, 35'(0), 3'(i));
    a_rst = 1'b1; a_valid = 1'b1; a_data = 32'(3);
    @(posedge clk); #1;
    a_rst = 1'b0; a_valid = 1'b0;
    chk("rw_out_valid", 64'(a_out_valid), 64'(0));
    chk("rw_out_data", 64'(a_out_data), 64'(0));
    chk("rw_count", 64'(a_cnt), 64'(0));
    chk("rw_in_ready", 64'(a_in_ready), 64'(1));
    for (int i = 1; i <= 8; i++)
      step_a($sformatf("rw_post%0d", i), 0, 1, 32'(1), 1, 1, (i == 8), 35'(8), 3'(i % 8));

    // B: average with floor toward -inf.
    step_b("b0", 16'(-3), 0, 16'(0), 2'(1));
    step_b("b1", 16'(-3), 0, 16'(0), 2'(2));
    step_b("b2", 16'(-3), 0, 16'(0), 2'(3));
    step_b("b3", 16'(-4), 1, 16'(-4), 2'(0));
    step_b("b4", 16'(4), 0, 16'(0), 2'(1));
    step_b("b5", 16'(4), 0, 16'(0), 2'(2));
    step_b("b6", 16'(4), 0, 16'(0), 2'(3));
    step_b("b7", 16'(5), 1, 16'(4), 2'(0));
    step_b("b8", 16'(-1), 0, 16'(0), 2'(1));
    step_b("b9", 16'(0), 0, 16'(0), 2'(2));
    step_b("b10", 16'(0), 0, 16'(0), 2'(3));
    step_b("b11", 16'(0), 1, 16'(-1), 2'(0));

    // C: full-scale positive and negative windows must not wrap.
    for (int i = 1; i <= 8; i++)
      step_c($sformatf("cpos%0d", i), 16'h7FFF, (i == 8), 19'h3FFF8, 3'(i % 8));
    for (int i = 1; i <= 8; i++)
      step_c($sformatf("cneg%0d", i), 16'h8000, (i == 8), 19'h40000, 3'(i % 8));

    // D: passthrough, back-to-back consume+load, stall, clear with sample completes.
    step_d("d0", 0, 1, 8'(5), 1, 1, 1, 8'(5));
    step_d("d1", 0, 1, 8'(-7), 1, 1, 1, 8'(-7));
    step_d("d2", 0, 1, 8'(100), 0, 0, 1, 8'(-7));
    step_d("d3", 0, 1, 8'(100), 0, 0, 1, 8'(-7));
    step_d("d4", 1, 1, 8'(33), 1, 1, 1, 8'(33));
    step_d("d5", 0, 0, 8'(0), 1, 1, 0, 8'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
